fp_add_responder: RTL and testbench
===================================

Name: fp_add_responder

Overview:
Single-precision floating-point adder that serves the `add_start`/`add_operand_a`/`add_operand_b` request side of the shared arithmetic interface. It returns `add_result_ready`/`add_result` to whichever sequencer currently drives the add lane (angle combination, angle normalization, term accumulator). One instance is placed per add lane (lanes 0 and 1). It is multi-cycle, non-pipelined and has a fixed latency.

Parameters:
- EXP_LEN, 8, exponent field width
- MANTISSA_LEN, 23, stored fraction width
- DATA_WIDTH, 32, operand width; must equal 1+EXP_LEN+MANTISSA_LEN

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- add_start  in  1  one-cycle request pulse; operands valid in the same cycle
- add_operand_a  in  DATA_WIDTH  IEEE-754 operand A
- add_operand_b  in  DATA_WIDTH  IEEE-754 operand B
- add_result  out  DATA_WIDTH  sum; holds its value until the next completion
- add_result_ready  out  1  one-cycle completion pulse
- add_busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high (ports `clock`, `reset`).
- Reset values: `add_result`=0, `add_result_ready`=0, `add_busy`=0, FSM=IDLE. Reset in any state aborts the operation with no ready pulse.
- FSM and transitions:
  - IDLE: if `add_start`, latch and unpack both operands, go to ALIGN. Otherwise stay.
  - ALIGN: swap so that |A| >= |B|; right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A shift >= MANTISSA_LEN+3 moves the whole significand into sticky.
  - ADD: add or subtract significands according to the sign XOR. Width is MANTISSA_LEN+5 (carry, hidden bit, fraction, G/R/S).
  - NORM: on carry-out, shift right by 1 and increment exponent. Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1.
  - ROUND: round to nearest even on G/R/S. A mantissa carry from rounding renormalizes and increments the exponent. Then apply overflow handling.
  - DONE: drive `add_result` and pulse `add_result_ready` for one cycle, return to IDLE.
- Latency: `add_start` sampled in IDLE at cycle 0 gives `add_result_ready`=1 in cycle 5.
- Handshake: `add_start` is ignored while `add_busy`=1 (states ALIGN through DONE). A back-to-back request is accepted no earlier than the cycle after DONE.
- Special cases:
  - Any NaN operand gives 0x7FC00000.
  - +inf + -inf gives 0x7FC00000.
  - inf + finite gives that inf.
  - Exponent overflow gives a correctly signed inf.
- Exact-zero sum is +0, except (-0)+(-0) which gives -0.
- A subnormal result or input is handled per the optional feature below.

Optional Feature:
- Macro: FP_ADD_SUBNORMAL_EN.
- Defined: subnormal inputs use hidden bit 0 and exponent 1. Results below the minimum normal are emitted as subnormals (gradual underflow).
- Undefined: subnormal inputs are treated as signed zero, and any result with exponent < 1 after rounding is flushed to signed zero.
- Latency is identical in both builds.

Decomposition:
- Package `fp_pkg` holds:
  - localparams for EXP_LEN, MANTISSA_LEN, BIAS and QNAN (0x7FC00000);
  - a packed struct typedef `fp_t {sign, exp, frac}`;
  - the FSM state enum `fp_add_state_t` (IDLE, ALIGN, ADD, NORM, ROUND, DONE).
- One sub-module, `leading_zero_counter`: parameterized width, combinational count used by NORM.

Test Plan:
- 0x3F800000 + 0x3F800000 pulsed at cycle 0 -> `add_result_ready` exactly at cycle 5, `add_result`=0x40000000, `add_busy` high cycles 1-5.
- 0x3F800000 + 0xBF800000 -> 0x00000000. 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) -> 0x3F800000. 0x3F800000 + 0x33800001 -> 0x3F800001.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- `add_start` re-pulsed at cycle 2 with other operands -> ignored, single ready at cycle 5 with the first sum. Reset asserted at cycle 3 -> no ready pulse, outputs return to 0 next cycle.
- 0x00000001 + 0x00000001 -> 0x00000002 with FP_ADD_SUBNORMAL_EN, 0x00000000 without.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants, operand layout and adder FSM states.
package fp_pkg;

  localparam int EXP_LEN      = 8;
  localparam int MANTISSA_LEN = 23;
  localparam int BIAS         = (1 << (EXP_LEN - 1)) - 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                    sign;
    logic [EXP_LEN-1:0]      exp;
    logic [MANTISSA_LEN-1:0] frac;
  } fp_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } fp_add_state_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count; an all-zero input returns WIDTH.
module leading_zero_counter #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_responder.sv
// Multi-cycle IEEE-754 adder for one add lane, fixed 5-cycle start-to-ready latency.
// Define FP_ADD_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_add_responder #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_start,
  input  logic [DATA_WIDTH-1:0] add_operand_a,
  input  logic [DATA_WIDTH-1:0] add_operand_b,
  output logic [DATA_WIDTH-1:0] add_result,
  output logic                  add_result_ready,
  output logic                  add_busy
);
  import fp_pkg::*;

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = MANTISSA_LEN + 1;   // hidden bit + fraction
  localparam int XW  = MANTISSA_LEN + 4;   // significand + guard/round/sticky
  localparam int AW  = MANTISSA_LEN + 5;   // plus carry
  localparam int EW  = EXP_LEN + 2;        // headroom for carry and round increments
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_LEN) - 1);
  localparam logic [DW-1:0] QNAN_W  =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  fp_add_state_t state;

  logic              a_sign, b_sign, both_neg, special;
  logic [EW-1:0]     a_exp, b_exp, res_exp;
  logic [SW-1:0]     a_sig, b_sig;
  logic [DW-1:0]     special_res;
  logic              res_sign, eff_sub, zero_r;
  logic [XW-1:0]     big_x, small_x, norm_x;
  logic [AW-1:0]     sum;

  function automatic logic [EW-1:0] eff_exp(input logic [EXP_LEN-1:0] e);
    return (e == '0) ? EW'(1) : EW'(e);
  endfunction

  function automatic logic [SW-1:0] eff_sig(input logic [EXP_LEN-1:0] e,
                                            input logic [MANTISSA_LEN-1:0] f);
`ifdef FP_ADD_SUBNORMAL_EN
    return {(e != '0), f};
`else
    return (e == '0) ? '0 : {1'b1, f};
`endif
  endfunction

  // Bits shifted out are OR-ed into the sticky position.
  function automatic logic [XW-1:0] shr_sticky(input logic [XW-1:0] x, input logic [EW-1:0] d);
    logic [XW-1:0] kept, lost;
    if (d >= EW'(XW - 1)) return {{(XW-1){1'b0}}, |x};
    kept = x >> d;
    lost = x << (EW'(XW) - d);
    return {kept[XW-1:1], kept[0] | (|lost)};
  endfunction

  // Operand classification, evaluated on the raw request in IDLE
  logic [EXP_LEN-1:0]      ea_raw, eb_raw;
  logic [MANTISSA_LEN-1:0] fa_raw, fb_raw;
  logic                    nan_a, nan_b, inf_a, inf_b;
  logic [DW-1:0]           special_c;

  always_comb begin
    ea_raw = add_operand_a[DW-2 -: EXP_LEN];
    eb_raw = add_operand_b[DW-2 -: EXP_LEN];
    fa_raw = add_operand_a[MANTISSA_LEN-1:0];
    fb_raw = add_operand_b[MANTISSA_LEN-1:0];
    nan_a  = (&ea_raw) && (fa_raw != '0);
    nan_b  = (&eb_raw) && (fb_raw != '0);
    inf_a  = (&ea_raw) && (fa_raw == '0);
    inf_b  = (&eb_raw) && (fb_raw == '0);
    if (nan_a || nan_b || (inf_a && inf_b && (add_operand_a[DW-1] != add_operand_b[DW-1])))
      special_c = QNAN_W;
    else if (inf_a)
      special_c = add_operand_a;
    else
      special_c = add_operand_b;
  end

  logic              swap;
  logic [EW-1:0]     big_exp_c, small_exp_c;
  logic [SW-1:0]     big_sig_c, small_sig_c;
  logic [XW-1:0]     small_x_c;

  always_comb begin
    swap        = {b_exp, b_sig} > {a_exp, a_sig};
    big_exp_c   = swap ? b_exp : a_exp;
    small_exp_c = swap ? a_exp : b_exp;
    big_sig_c   = swap ? b_sig : a_sig;
    small_sig_c = swap ? a_sig : b_sig;
    small_x_c   = shr_sticky({small_sig_c, 3'b000}, big_exp_c - small_exp_c);
  end

  logic [LZW-1:0] lz;
  logic [EW-1:0]  lim, shamt;

  leading_zero_counter #(.WIDTH(XW), .CW(LZW)) u_lzc (
    .value (sum[XW-1:0]),
    .count (lz)
  );

  // Normalizing left shift never takes the exponent below 1.
  always_comb begin
    lim   = res_exp - EW'(1);
    shamt = (EW'(lz) > lim) ? lim : EW'(lz);
  end

  logic [SW-1:0]           mant;
  logic [SW:0]             mant_r;
  logic                    rup;
  logic [MANTISSA_LEN-1:0] frac_r;
  logic [EW-1:0]           exp_r;
  logic [DW-1:0]           result_c;

  always_comb begin
    mant   = norm_x[XW-1:3];
    rup    = norm_x[2] & (norm_x[1] | norm_x[0] | norm_x[3]);
    mant_r = {1'b0, mant} + {{SW{1'b0}}, rup};
    if (mant_r[SW]) begin
      frac_r = mant_r[SW-1:1];
      exp_r  = res_exp + EW'(1);
    end else begin
      frac_r = mant_r[SW-2:0];
      exp_r  = mant_r[SW-1] ? res_exp : '0;
    end
    if (special)
      result_c = special_res;
    else if (zero_r)
      result_c = {both_neg, {(DW-1){1'b0}}};
    else if (exp_r >= EXP_MAX)
      result_c = {res_sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    else if (exp_r == '0) begin
`ifdef FP_ADD_SUBNORMAL_EN
      result_c = {res_sign, {EXP_LEN{1'b0}}, frac_r};
`else
      result_c = {res_sign, {(DW-1){1'b0}}};
`endif
    end else
      result_c = {res_sign, exp_r[EXP_LEN-1:0], frac_r};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      add_result       <= '0;
      add_result_ready <= 1'b0;
      add_busy         <= 1'b0;
      a_sign <= 1'b0; b_sign <= 1'b0; both_neg <= 1'b0; special <= 1'b0;
      a_exp  <= '0;   b_exp  <= '0;   a_sig    <= '0;   b_sig   <= '0;
      special_res <= '0;
      res_sign <= 1'b0; eff_sub <= 1'b0; zero_r <= 1'b0; res_exp <= '0;
      big_x <= '0; small_x <= '0; norm_x <= '0; sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          add_result_ready <= 1'b0;
          if (add_start) begin
            a_sign      <= add_operand_a[DW-1];
            b_sign      <= add_operand_b[DW-1];
            both_neg    <= add_operand_a[DW-1] & add_operand_b[DW-1];
            a_exp       <= eff_exp(ea_raw);
            b_exp       <= eff_exp(eb_raw);
            a_sig       <= eff_sig(ea_raw, fa_raw);
            b_sig       <= eff_sig(eb_raw, fb_raw);
            special     <= nan_a | nan_b | inf_a | inf_b;
            special_res <= special_c;
            add_busy    <= 1'b1;
            state       <= ALIGN;
          end
        end
        ALIGN: begin
          res_sign <= swap ? b_sign : a_sign;
          eff_sub  <= a_sign ^ b_sign;
          res_exp  <= big_exp_c;
          big_x    <= {big_sig_c, 3'b000};
          small_x  <= small_x_c;
          state    <= ADD;
        end
        ADD: begin
          sum   <= eff_sub ? ({1'b0, big_x} - {1'b0, small_x})
                           : ({1'b0, big_x} + {1'b0, small_x});
          state <= NORM;
        end
        NORM: begin
          zero_r <= (sum == '0);
          if (sum[AW-1]) begin
            norm_x  <= {sum[AW-1:2], |sum[1:0]};
            res_exp <= res_exp + EW'(1);
          end else begin
            norm_x  <= sum[XW-1:0] << shamt;
            res_exp <= res_exp - shamt;
          end
          state <= ROUND;
        end
        ROUND: begin
          add_result       <= result_c;
          add_result_ready <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          add_result_ready <= 1'b0;
          add_busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_responder.sv
// Bench for fp_add_responder: directed table, timing/handshake sequences, random vs exact-integer model.
module tb_fp_add_responder;
  import fp_pkg::*;

  logic        clock = 1'b0;
  logic        reset, add_start;
  logic [31:0] add_operand_a, add_operand_b, add_result;
  logic        add_result_ready, add_busy;

  int checks = 0;
  int failures = 0;

  fp_add_responder dut (
    .clock            (clock),
    .reset            (reset),
    .add_start        (add_start),
    .add_operand_a    (add_operand_a),
    .add_operand_b    (add_operand_b),
    .add_result       (add_result),
    .add_result_ready (add_result_ready),
    .add_busy         (add_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t        vecs[12];
  logic [10:0] busy_v, ready_v;
  logic [31:0] res_v[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Exact magnitude in units of 2^-149, so every finite float is an integer.
  function automatic logic [299:0] mag_of(input fp_t f);
    logic [299:0] m;
    if (f.exp == 8'd0) begin
`ifdef FP_ADD_SUBNORMAL_EN
      return 300'(f.frac);
`else
      return '0;
`endif
    end
    m = 300'(f.frac) | (300'(1) << 23);
    return m << (f.exp - 8'd1);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    fp_t fa, fb;
    logic [299:0] ma, mb, mag, mant, rem, half;
    logic sign;
    logic [31:0] res;
    int p, sh, e;
    fa = a;
    fb = b;
    if ((fa.exp == 8'hFF && fa.frac != 0) || (fb.exp == 8'hFF && fb.frac != 0)) return QNAN;
    if (fa.exp == 8'hFF && fb.exp == 8'hFF) return (fa.sign != fb.sign) ? QNAN : a;
    if (fa.exp == 8'hFF) return a;
    if (fb.exp == 8'hFF) return b;
    ma = mag_of(fa);
    mb = mag_of(fb);
    if (fa.sign == fb.sign) begin mag = ma + mb; sign = fa.sign; end
    else if (ma >= mb)      begin mag = ma - mb; sign = fa.sign; end
    else                    begin mag = mb - ma; sign = fb.sign; end
    if (mag == 0) return {fa.sign & fb.sign, 31'b0};
    p = 0;
    for (int i = 299; i >= 0; i--) if (mag[i]) begin p = i; break; end
    if (p < 24) begin
      res = {sign, mag[30:0]};
`ifndef FP_ADD_SUBNORMAL_EN
      if (res[30:23] == 8'd0) res = {sign, 31'b0};
`endif
      return res;
    end
    sh   = p - 23;
    mant = mag >> sh;
    rem  = mag - (mant << sh);
    half = 300'(1) << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant[24]) begin mant = mant >> 1; sh++; end
    e = sh + 1;
    if (e >= 255) return {sign, 8'hFF, 23'b0};
    return {sign, 8'(e), mant[22:0]};
  endfunction

  // One request; lat is the cycle index of the ready pulse (start edge = cycle 0), -1 on timeout.
  task automatic do_add(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    add_operand_a = a;
    add_operand_b = b;
    add_start = 1'b1;
    step();
    add_start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (add_result_ready) begin lat = c; break; end
      step();
    end
    res = add_result;
    step();
  endtask

  // Records busy/ready/result for cycles 1..10, optionally re-pulsing start or asserting reset.
  task automatic track(input logic [31:0] a, input logic [31:0] b,
                       input int restart_c, input int reset_c);
    add_operand_a = a;
    add_operand_b = b;
    add_start = 1'b1;
    step();
    add_start = 1'b0;
    busy_v = '0;
    ready_v = '0;
    for (int c = 1; c <= 10; c++) begin
      busy_v[c]  = add_busy;
      ready_v[c] = add_result_ready;
      res_v[c]   = add_result;
      add_start  = (c == restart_c);
      if (c == restart_c) begin
        add_operand_a = 32'h4040_0000;
        add_operand_b = 32'h4040_0000;
      end
      reset = (c == reset_c);
      step();
    end
    add_start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] res, a, b;
    int lat;

    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    vecs[1]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[3]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
    vecs[4]  = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001};
    vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
    vecs[6]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
    vecs[7]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000};
    vecs[9]  = '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000};
    vecs[10] = '{32'h4040_0000, 32'hC000_0000, 32'h3F80_0000};
`ifdef FP_ADD_SUBNORMAL_EN
    vecs[8]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
    vecs[11] = '{32'h0080_0000, 32'h80C0_0000, 32'h8040_0000};
`else
    vecs[8]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{32'h0080_0000, 32'h80C0_0000, 32'h8000_0000};
`endif

    reset = 1'b1;
    add_start = 1'b0;
    add_operand_a = '0;
    add_operand_b = '0;
    step();
    step();
    chk("reset_result", add_result, 32'h0);
    chk("reset_ready", {31'b0, add_result_ready}, 32'h0);
    chk("reset_busy", {31'b0, add_busy}, 32'h0);
    reset = 1'b0;
    step();

    track(32'h3F80_0000, 32'h3F80_0000, 0, 0);
    chk("timing_busy", {21'b0, busy_v}, 32'h0000_003E);
    chk("timing_ready", {21'b0, ready_v}, 32'h0000_0020);
    chk("timing_result", res_v[5], 32'h4000_0000);

    for (int i = 0; i < 12; i++) begin
      do_add(vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_latency", i), lat, 32'd5);
    end

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[30:23] = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        b = {1'($urandom), a[30:23] + 8'($urandom_range(0, 3)) - 8'd1, 23'($urandom)};
      else
        b = $urandom;
      do_add(a, b, res, lat);
      chk($sformatf("rand%0d %h+%h", i, a, b), res, ref_add(a, b));
      if (lat != 5) chk($sformatf("rand%0d_latency", i), lat, 32'd5);
    end

    track(32'h3F80_0000, 32'h3F80_0000, 2, 0);
    chk("restart_busy", {21'b0, busy_v}, 32'h0000_003E);
    chk("restart_ready", {21'b0, ready_v}, 32'h0000_0020);
    chk("restart_result", res_v[5], 32'h4000_0000);
    chk("restart_result_held", res_v[10], 32'h4000_0000);

    track(32'h4040_0000, 32'h4040_0000, 0, 3);
    chk("abort_busy", {21'b0, busy_v}, 32'h0000_000E);
    chk("abort_ready", {21'b0, ready_v}, 32'h0);
    chk("abort_result_before", res_v[3], 32'h4000_0000);
    chk("abort_result_cleared", res_v[4], 32'h0);

    do_add(32'h4000_0000, 32'h3F80_0000, res, lat);
    chk("post_abort_result", res, 32'h4040_0000);
    chk("post_abort_latency", lat, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
